output_dma: RTL and testbench

OUTPUT_DMA -- requirements
Module: output_dma

---
 rtl/output_dma.sv | 123 ++++++++++++
 tb/tb_output_dma.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_dma.sv
// output_dma: streams BLOCK_SIZE samples from a result buffer (1-cycle read
// latency) onto a valid/ready stream, absorbing backpressure in a 2-entry skid
// FIFO. Optional CRC-16-CCITT over accepted samples via OUTPUT_DMA_CRC_EN.
module output_dma #(
  parameter int BLOCK_SIZE = 256,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_dma_out,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  dma_busy,
  output logic                  dma_done
`ifdef OUTPUT_DMA_CRC_EN
  ,
  output logic [15:0]           crc_out
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLOCK_SIZE - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;      // next read address
  logic [ADDR_WIDTH-1:0] out_idx;   // index of the sample at the stream head
  logic                  rd_all;    // every address of this block has been issued
  logic                  inflight;  // read issued last cycle, data on rd_data now
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic                  pop, push, fifo_pop;

  // Read only when the skid FIFO plus the in-flight read leave room for one more.
  assign rd_en    = (state == STREAM) && !rd_all && ((occ + {1'b0, inflight}) < 2'd2);
  assign rd_addr  = addr;

  // Stream head: FIFO entry if any, otherwise the read data arriving this cycle.
  assign m_valid  = (state == STREAM) && ((occ != 2'd0) || inflight);
  assign m_data   = !m_valid ? '0 : ((occ != 2'd0) ? fifo[rd_ptr] : rd_data);
  assign m_last   = m_valid && (out_idx == LAST_ADDR);

  assign pop      = m_valid && m_ready;
  assign fifo_pop = pop && (occ != 2'd0);
  // Arriving data bypasses the FIFO only when it is consumed on arrival.
  assign push     = inflight && !(pop && (occ == 2'd0));

  assign dma_busy = (state != IDLE);
  assign dma_done = (state == DONE);

  // Control FSM, address generation and skid FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      out_idx  <= '0;
      rd_all   <= 1'b0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        addr <= addr + 1'b1;
        if (addr == LAST_ADDR) rd_all <= 1'b1;
      end
      if (push) begin
        fifo[wr_ptr] <= rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
      if (pop) out_idx <= out_idx + 1'b1;

      case (state)
        IDLE: if (start_dma_out) begin
          state   <= STREAM;
          addr    <= '0;
          out_idx <= '0;
          rd_all  <= 1'b0;
          wr_ptr  <= 1'b0;
          rd_ptr  <= 1'b0;
          occ     <= 2'd0;
        end
        STREAM: if (pop && m_last) state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_DMA_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [DATA_WIDTH-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // CRC accumulates over accepted samples; holds after the block until next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             crc_out <= 16'hFFFF;
    else if ((state == IDLE) && start_dma_out) crc_out <= 16'hFFFF;
    else if (pop)                             crc_out <= crc_upd(crc_out, m_data);
  end
`endif

endmodule

// File: tb/tb_output_dma.sv
// tb_output_dma: directed tests for output_dma with a transaction-level model
// (expected-sample queue, read bookkeeping) checked every cycle on the falling edge.
module tb_output_dma;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_dma_out;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_last, dma_busy, dma_done;

  logic        start1;
  logic        rd_en1;
  logic [7:0]  rd_addr1;
  logic [15:0] rd_data1;
  logic [15:0] m_data1;
  logic        m_valid1, m_last1, busy1, done1;
`ifdef OUTPUT_DMA_CRC_EN
  logic [15:0] crc_out, crc1;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  output_dma #(.BLOCK_SIZE(B), .DATA_WIDTH(16), .ADDR_WIDTH(8)) u4 (
    .clk(clk), .reset_n(reset_n), .start_dma_out(start_dma_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .dma_busy(dma_busy), .dma_done(dma_done)
`ifdef OUTPUT_DMA_CRC_EN
    , .crc_out(crc_out)
`endif
  );

  output_dma #(.BLOCK_SIZE(1), .DATA_WIDTH(16), .ADDR_WIDTH(8)) u1 (
    .clk(clk), .reset_n(reset_n), .start_dma_out(start1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(1'b1), .m_last(m_last1),
    .dma_busy(busy1), .dma_done(done1)
`ifdef OUTPUT_DMA_CRC_EN
    , .crc_out(crc1)
`endif
  );

  // Result buffers: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    rd_data  <= rd_en  ? mem[rd_addr] : 16'hDEAD;
    rd_data1 <= rd_en1 ? 16'h0000     : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // ---------------- model ----------------
  logic [15:0] q[$];
  logic [15:0] acc_data[$];
  int          acc_cyc[$];
  int          done_cnt = 0, done_cyc = 0;
  bit          active = 0, done_exp = 0, prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_last;
  int          exp_addr, issued, accepted, since;
  logic [15:0] crc_exp;

  always @(negedge clk) begin
    bit hs, fin, was_idle;
    if (!reset_n) begin
      chk("rst_rd_en", rd_en, 0);     chk("rst_rd_addr", rd_addr, 0);
      chk("rst_m_valid", m_valid, 0); chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);   chk("rst_busy", dma_busy, 0);
      chk("rst_done", dma_done, 0);
      active = 0; done_exp = 0; prev_stall = 0; q.delete();
    end else begin
      chk("dma_done", dma_done, done_exp);
      chk("dma_busy", dma_busy, active || done_exp);
      if (done_exp) begin
        done_cnt++; done_cyc = cyc;
`ifdef OUTPUT_DMA_CRC_EN
        chk("crc_at_done", crc_out, crc_exp);
`endif
      end
      if (!active) chk("rd_en_idle", rd_en, 0);
      if (rd_en) begin
        chk("rd_addr", rd_addr, exp_addr);
        chk("rd_range", exp_addr < B, 1);
        chk("rd_outstanding", (issued - accepted) < 2, 1);
      end
      if (prev_stall) begin
        chk("valid_hold", m_valid, 1);
        chk("data_hold", m_data, prev_data);
        chk("last_hold", m_last, prev_last);
      end
      if (active && since == 2) chk("first_valid", m_valid, 1);
      if (m_valid) begin
        if (q.size() == 0) chk("valid_unexp", m_valid, 0);
        else begin
          chk("m_data", m_data, q[0]);
          chk("m_last", m_last, q.size() == 1);
        end
      end else chk("last_no_valid", m_last, 0);

      // advance to the next edge
      was_idle = !active && !done_exp;
      hs  = m_valid && m_ready && (q.size() > 0);
      fin = hs && (q.size() == 1);
      if (rd_en) begin issued++; exp_addr++; end
      if (hs) begin
        acc_data.push_back(m_data); acc_cyc.push_back(cyc);
        accepted++;
        crc_exp = crc_ref(crc_exp, q[0]);
        void'(q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      done_exp   = fin;
      if (fin) active = 0;
      since++;
      if (was_idle && start_dma_out) begin
        active = 1; exp_addr = 0; issued = 0; accepted = 0; since = 1;
        crc_exp = 16'hFFFF;
        for (int i = 0; i < B; i++) q.push_back(mem[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_log();
    acc_data.delete(); acc_cyc.delete(); done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_dma_out = 1'b1;
    @(posedge clk); #1 start_dma_out = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < maxc) begin @(posedge clk); n++; end
    chk(name, done_cnt != d0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string name, input logic [15:0] e [4]);
    chk({name, "_count"}, acc_data.size(), 4);
    for (int i = 0; i < 4 && i < acc_data.size(); i++) chk({name, "_data"}, acc_data[i], e[i]);
  endtask

  task automatic load(input logic [15:0] e [4]);
    for (int i = 0; i < 4; i++) mem[i] = e[i];
  endtask

  logic [15:0] v1 [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [15:0] v2 [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
  logic [15:0] v4 [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  bit          rdy_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hEEEE;
    reset_n = 1'b0; start_dma_out = 1'b0; m_ready = 1'b1; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // full-rate stream
    load(v1); clear_log();
    pulse_start();
    wait_done("t1_done", 40);
    check_seq("t1", v1);
    if (acc_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t1_consecutive", acc_cyc[i] - acc_cyc[0], i);
      chk("t1_done_delay", done_cyc - acc_cyc[3], 1);
    end
    chk("t1_done_count", done_cnt, 1);

    // backpressure pattern
    load(v2); clear_log();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      m_ready = rdy_pat[i];
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_done("t2_done", 40);
    check_seq("t2", v2);
    chk("t2_done_count", done_cnt, 1);

    // second start mid-transfer is ignored
    load(v1); clear_log();
    pulse_start();
    @(posedge clk); #1 start_dma_out = 1'b1;
    @(posedge clk); #1 start_dma_out = 1'b0;
    wait_done("t3_done", 40);
    repeat (6) @(posedge clk);
    #1;
    check_seq("t3", v1);
    chk("t3_done_count", done_cnt, 1);
    chk("t3_idle_busy", dma_busy, 0);

    // reset after two samples, then restart from address 0
    load(v4); clear_log();
    pulse_start();
    for (int n = 0; n < 20 && acc_data.size() < 2; n++) @(negedge clk);
    chk("t4_two_samples", acc_data.size(), 2);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_valid", m_valid, 0);
    chk("t4_rst_data", m_data, 0);
    chk("t4_rst_busy", dma_busy, 0);
    clear_log();
    @(posedge clk); #1 reset_n = 1'b1; start_dma_out = 1'b1;
    @(posedge clk); #1 start_dma_out = 1'b0;
    wait_done("t4_done", 40);
    check_seq("t4", v4);

    // single-sample block
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("t5_rd_en", rd_en1, 1);
    chk("t5_rd_addr", rd_addr1, 0);
    chk("t5_busy", busy1, 1);
    @(negedge clk);
    chk("t5_valid", m_valid1, 1);
    chk("t5_last", m_last1, 1);
    chk("t5_data", m_data1, 16'h0000);
    chk("t5_no_read", rd_en1, 0);
    @(negedge clk);
    chk("t5_done", done1, 1);
    chk("t5_valid_off", m_valid1, 0);
`ifdef OUTPUT_DMA_CRC_EN
    chk("t5_crc", crc1, 16'h1D0F);
`endif
    @(negedge clk);
    chk("t5_done_pulse", done1, 0);
    chk("t5_idle", busy1, 0);
`ifdef OUTPUT_DMA_CRC_EN
    chk("t5_crc_hold", crc1, 16'h1D0F);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
